// File: rtl/exu_wb_pkg.sv
// Shared definitions for the execution-unit writeback arbiter.
//   REG_AW   : register-file address width
//   REG_DW   : register-file data width
//   wb_req_t : one register write (valid, destination, data)
package exu_wb_pkg;

    localparam int unsigned REG_AW = 5;
    localparam int unsigned REG_DW = 32;

    typedef struct packed {
        logic              vld;
        logic [REG_AW-1:0] addr;
        logic [REG_DW-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/exu_wb_rr_arb.sv
// Combinational round-robin pick among eligible requesters.
//   eligible  : per-requester request bits
//   rr_ptr    : index searched first; the search wraps past NUM_REQ-1
//   grant     : one-hot grant (all zero when nothing is eligible)
//   grant_idx : binary index of the granted requester
//   any       : a grant was issued
module exu_wb_rr_arb #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned PW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [PW-1:0]      rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PW-1:0]      grant_idx,
    output logic               any
);

    always_comb begin
        logic [PW-1:0] idx;
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        idx       = '0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            idx = PW'((32'(rr_ptr) + off) % NUM_REQ);
            if (!any && eligible[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/exu_wb_arbiter.sv
// Round-robin arbiter for the single register-file write port.
//   hclk, hrstn          : clock (rising edge), asynchronous active-low reset
//   req_wen/waddr/wdata  : per-requester one-cycle write pulses (slice i = requester i)
//   reg_wen/waddr/wdata  : registered write port, one write per cycle at most
//   exu_stall            : some requester still holds a pending write
//   err_ovf / err_clr    : sticky "write dropped" flag and its synchronous clear
module exu_wb_arbiter
    import exu_wb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned AW      = REG_AW,
    parameter int unsigned DW      = REG_DW
) (
    input  logic                  hclk,
    input  logic                  hrstn,
    input  logic [NUM_REQ-1:0]    req_wen,
    input  logic [NUM_REQ*AW-1:0] req_waddr,
    input  logic [NUM_REQ*DW-1:0] req_wdata,
    output logic                  reg_wen,
    output logic [AW-1:0]         reg_waddr,
    output logic [DW-1:0]         reg_wdata,
    output logic                  exu_stall,
    output logic                  err_ovf,
    input  logic                  err_clr
);

    localparam int unsigned PW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] pend_vld_q, pend_vld_d;
    logic [AW-1:0]      pend_addr_q [NUM_REQ];
    logic [AW-1:0]      pend_addr_d [NUM_REQ];
    logic [DW-1:0]      pend_data_q [NUM_REQ];
    logic [DW-1:0]      pend_data_d [NUM_REQ];

    logic [AW-1:0]      in_addr [NUM_REQ];
    logic [DW-1:0]      in_data [NUM_REQ];
    logic [NUM_REQ-1:0] in_live, in_ok, in_ovf, in_acc;
    logic [NUM_REQ-1:0] eligible, grant;
    logic [PW-1:0]      grant_idx, rr_ptr_q, rr_ptr_d;
    logic               grant_any;

    logic               reg_wen_q, reg_wen_d;
    logic [AW-1:0]      reg_waddr_q, reg_waddr_d;
    logic [DW-1:0]      reg_wdata_q, reg_wdata_d;
    logic               err_q, err_d;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            in_addr[i] = req_waddr[i*AW +: AW];
            in_data[i] = req_wdata[i*DW +: DW];
        end
    end

    // Writes to x0 vanish here; among same-cycle writes to one address only the
    // lowest requester survives.
    always_comb begin
        in_live = '0;
        in_ok   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            in_live[i] = req_wen[i] && (in_addr[i] != '0);
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            in_ok[i] = in_live[i];
            for (int j = 0; j < i; j++) begin
                if (in_live[j] && (in_addr[j] == in_addr[i])) in_ok[i] = 1'b0;
            end
        end
    end

    assign eligible = pend_vld_q | in_ok;

    exu_wb_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .PW      (PW)
    ) u_rr_arb (
        .eligible  (eligible),
        .rr_ptr    (rr_ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (grant_any)
    );

    // An incoming write is lost only when its slot stays occupied by a
    // different destination; everything else in in_ok is accepted.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            in_ovf[i] = in_ok[i] && pend_vld_q[i] && !grant[i] && (pend_addr_q[i] != in_addr[i]);
        end
    end

    assign in_acc = in_ok & ~in_ovf;

    always_comb begin
        logic cancel;
        cancel      = 1'b0;
        reg_wen_d   = grant_any;
        reg_waddr_d = '0;
        reg_wdata_d = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                reg_waddr_d = pend_vld_q[i] ? pend_addr_q[i] : in_addr[i];
                reg_wdata_d = pend_vld_q[i] ? pend_data_q[i] : in_data[i];
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            pend_vld_d[i]  = pend_vld_q[i];
            pend_addr_d[i] = pend_addr_q[i];
            pend_data_d[i] = pend_data_q[i];
            // A newer accepted write to the same register makes this entry stale.
            cancel = 1'b0;
            for (int k = 0; k < NUM_REQ; k++) begin
                if ((k != i) && in_acc[k] && (in_addr[k] == pend_addr_q[i])) cancel = 1'b1;
            end
            if (grant[i] || cancel) pend_vld_d[i] = 1'b0;
            // Capture unless the incoming write itself went straight out.
            if (in_acc[i] && !(grant[i] && !pend_vld_q[i])) begin
                pend_vld_d[i]  = 1'b1;
                pend_addr_d[i] = in_addr[i];
                pend_data_d[i] = in_data[i];
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant_any) begin
            rr_ptr_d = (grant_idx == PW'(NUM_REQ - 1)) ? '0 : grant_idx + PW'(1);
        end
        err_d = err_q;
        if (|in_ovf) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge hclk or negedge hrstn) begin
        if (!hrstn) begin
            pend_vld_q  <= '0;
            rr_ptr_q    <= '0;
            reg_wen_q   <= 1'b0;
            reg_waddr_q <= '0;
            reg_wdata_q <= '0;
            err_q       <= 1'b0;
            for (int i = 0; i < NUM_REQ; i++) begin
                pend_addr_q[i] <= '0;
                pend_data_q[i] <= '0;
            end
        end else begin
            pend_vld_q  <= pend_vld_d;
            rr_ptr_q    <= rr_ptr_d;
            reg_wen_q   <= reg_wen_d;
            reg_waddr_q <= reg_waddr_d;
            reg_wdata_q <= reg_wdata_d;
            err_q       <= err_d;
            for (int i = 0; i < NUM_REQ; i++) begin
                pend_addr_q[i] <= pend_addr_d[i];
                pend_data_q[i] <= pend_data_d[i];
            end
        end
    end

    assign reg_wen   = reg_wen_q;
    assign reg_waddr = reg_waddr_q;
    assign reg_wdata = reg_wdata_q;
    assign exu_stall = |pend_vld_q;
    assign err_ovf   = err_q;

endmodule

// File: tb/tb_exu_wb_arbiter.sv
// Self-checking bench for exu_wb_arbiter: directed vector table, fairness and
// reset sequences, then random traffic against a behavioural model.
module tb_exu_wb_arbiter;
    import exu_wb_pkg::*;

    localparam int NR = 4;
    localparam int AW = 5;
    localparam int DW = 32;

    logic                 hclk;
    logic                 hrstn;
    logic [NR-1:0]        tb_wen;
    logic [AW-1:0]        tb_addr [NR];
    logic [DW-1:0]        tb_data [NR];
    logic                 tb_clr;
    logic [NR*AW-1:0]     req_waddr;
    logic [NR*DW-1:0]     req_wdata;
    logic                 reg_wen;
    logic [AW-1:0]        reg_waddr;
    logic [DW-1:0]        reg_wdata;
    logic                 exu_stall;
    logic                 err_ovf;

    int n_checks = 0;
    int n_fail   = 0;

    always_comb begin
        for (int i = 0; i < NR; i++) begin
            req_waddr[i*AW +: AW] = tb_addr[i];
            req_wdata[i*DW +: DW] = tb_data[i];
        end
    end

    exu_wb_arbiter #(
        .NUM_REQ (NR),
        .AW      (AW),
        .DW      (DW)
    ) dut (
        .hclk      (hclk),
        .hrstn     (hrstn),
        .req_wen   (tb_wen),
        .req_waddr (req_waddr),
        .req_wdata (req_wdata),
        .reg_wen   (reg_wen),
        .reg_waddr (reg_waddr),
        .reg_wdata (reg_wdata),
        .exu_stall (exu_stall),
        .err_ovf   (err_ovf),
        .err_clr   (tb_clr)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    // ---------------- behavioural model ----------------
    int            m_ptr;
    bit            m_pv [NR];
    logic [AW-1:0] m_pa [NR];
    logic [DW-1:0] m_pd [NR];
    bit            m_err;
    bit            e_wen;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    bit            e_stall;

    task automatic model_reset();
        m_ptr   = 0;
        m_err   = 0;
        e_stall = 0;
        for (int i = 0; i < NR; i++) begin
            m_pv[i] = 0;
            m_pa[i] = '0;
            m_pd[i] = '0;
        end
    endtask

    task automatic model_step();
        bit      raw [NR];
        bit      live [NR];
        bit      cap [NR];
        bit      nv [NR];
        bit      drop;
        int      g;
        wb_req_t w;
        wb_req_t acc_q[$];
        int      own_q[$];
        drop = 0;
        g    = -1;
        for (int i = 0; i < NR; i++) raw[i] = tb_wen[i] && (tb_addr[i] != '0);
        for (int i = 0; i < NR; i++) begin
            live[i] = raw[i];
            for (int j = 0; j < i; j++) if (raw[j] && tb_addr[j] == tb_addr[i]) live[i] = 0;
        end
        for (int k = 0; k < NR; k++) begin
            int idx;
            idx = (m_ptr + k) % NR;
            if (g < 0 && (m_pv[idx] || live[idx])) g = idx;
        end
        e_wen  = 0;
        e_addr = '0;
        e_data = '0;
        for (int i = 0; i < NR; i++) begin
            nv[i]  = m_pv[i];
            cap[i] = 0;
        end
        if (g >= 0) begin
            e_wen = 1;
            if (m_pv[g]) begin
                e_addr = m_pa[g];
                e_data = m_pd[g];
                nv[g]  = 0;
            end else begin
                e_addr = tb_addr[g];
                e_data = tb_data[g];
                w.vld = 1'b1; w.addr = tb_addr[g]; w.data = tb_data[g];
                acc_q.push_back(w);
                own_q.push_back(g);
                live[g] = 0;
            end
            m_ptr = (g + 1) % NR;
        end
        for (int i = 0; i < NR; i++) begin
            if (live[i]) begin
                if (!m_pv[i] || g == i || m_pa[i] == tb_addr[i]) begin
                    cap[i] = 1;
                    w.vld = 1'b1; w.addr = tb_addr[i]; w.data = tb_data[i];
                    acc_q.push_back(w);
                    own_q.push_back(i);
                end else begin
                    drop = 1;
                end
            end
        end
        for (int q = 0; q < acc_q.size(); q++) begin
            for (int s = 0; s < NR; s++) begin
                if (s != own_q[q] && nv[s] && m_pa[s] == acc_q[q].addr) nv[s] = 0;
            end
        end
        e_stall = 0;
        for (int i = 0; i < NR; i++) begin
            m_pv[i] = nv[i] | cap[i];
            if (cap[i]) begin
                m_pa[i] = tb_addr[i];
                m_pd[i] = tb_data[i];
            end
            e_stall = e_stall | m_pv[i];
        end
        m_err = drop ? 1'b1 : (tb_clr ? 1'b0 : m_err);
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic set_idle();
        tb_wen = '0;
        tb_clr = 1'b0;
        for (int i = 0; i < NR; i++) begin
            tb_addr[i] = '0;
            tb_data[i] = '0;
        end
    endtask

    task automatic tick(input bit cmp);
        model_step();
        @(posedge hclk);
        #1;
        if (cmp) begin
            chk("m_wen", 32'(reg_wen), 32'(e_wen));
            chk("m_waddr", 32'(reg_waddr), 32'(e_addr));
            chk("m_wdata", reg_wdata, e_data);
            chk("m_stall", 32'(exu_stall), 32'(e_stall));
            chk("m_err", 32'(err_ovf), 32'(m_err));
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct packed {
        logic [NR-1:0]    wen;
        logic [NR*AW-1:0] addr;
        logic [NR*DW-1:0] data;
        logic             clr;
        logic             ew;
        logic [AW-1:0]    ea;
        logic [DW-1:0]    ed;
        logic             es;
        logic             ee;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] wen, input int a3, input int a2, input int a1,
                                input int a0, input logic [31:0] d3, input logic [31:0] d2,
                                input logic [31:0] d1, input logic [31:0] d0, input bit clr,
                                input bit ew, input int ea, input logic [31:0] ed, input bit es,
                                input bit ee);
        vec_t v;
        v.wen  = wen;
        v.addr = {5'(a3), 5'(a2), 5'(a1), 5'(a0)};
        v.data = {d3, d2, d1, d0};
        v.clr  = clr;
        v.ew   = ew;
        v.ea   = 5'(ea);
        v.ed   = ed;
        v.es   = es;
        v.ee   = ee;
        return v;
    endfunction

    vec_t vecs [24];

    initial begin
        bit exp_hi;
        // contention from rr_ptr=0, then pointer position probe (should be 3)
        vecs[0]  = mk(4'b0111, 0, 3, 2, 1, 0, 'h33, 'h22, 'h11, 0, 1, 1, 'h11, 1, 0);
        vecs[1]  = mk(4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 'h22, 1, 0);
        vecs[2]  = mk(4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 'h33, 0, 0);
        vecs[3]  = mk(4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[4]  = mk(4'b1001, 5, 0, 0, 4, 'h55, 0, 0, 'h44, 0, 1, 5, 'h55, 1, 0);
        vecs[5]  = mk(4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 'h44, 0, 0);
        // single write
        vecs[6]  = mk(4'b0001, 0, 0, 0, 5, 0, 0, 0, 'h12345000, 0, 1, 5, 'h12345000, 0, 0);
        vecs[7]  = mk(4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // supersede: req3 pending on x7 with A, req2 writes x7 with B
        vecs[8]  = mk(4'b1010, 7, 0, 9, 0, 'hA, 0, 'h90, 0, 0, 1, 9, 'h90, 1, 0);
        vecs[9]  = mk(4'b0100, 0, 7, 0, 0, 0, 'hB, 0, 0, 0, 1, 7, 'hB, 0, 0);
        vecs[10] = mk(4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // x0 write discarded
        vecs[11] = mk(4'b1000, 0, 0, 0, 0, 'hFF, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // overflow on req0, addr 4 still written, then clear
        vecs[12] = mk(4'b0001, 0, 0, 0, 6, 0, 0, 0, 'h06, 0, 1, 6, 'h06, 0, 0);
        vecs[13] = mk(4'b0011, 0, 0, 1, 4, 0, 0, 'h11, 'h04, 0, 1, 1, 'h11, 1, 0);
        vecs[14] = mk(4'b0101, 0, 2, 0, 9, 0, 'h22, 0, 'h09, 0, 1, 2, 'h22, 1, 1);
        vecs[15] = mk(4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 'h04, 0, 1);
        vecs[16] = mk(4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        vecs[17] = mk(4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        // overflow set wins over a same-cycle clear
        vecs[18] = mk(4'b0011, 0, 0, 1, 4, 0, 0, 'h11, 'h04, 0, 1, 1, 'h11, 1, 0);
        vecs[19] = mk(4'b0101, 0, 2, 0, 9, 0, 'h22, 0, 'h09, 1, 1, 2, 'h22, 1, 1);
        vecs[20] = mk(4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 'h04, 0, 1);
        vecs[21] = mk(4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        // same-cycle collision on x12: lowest index wins, other dropped silently
        vecs[22] = mk(4'b0101, 0, 12, 0, 12, 0, 'hC2, 0, 'hC0, 0, 1, 12, 'hC0, 0, 0);
        vecs[23] = mk(4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        hrstn = 1'b0;
        set_idle();
        model_reset();
        #12;
        hrstn = 1'b1;
        @(posedge hclk);
        #1;
        chk("rst_wen", 32'(reg_wen), 32'd0);
        chk("rst_waddr", 32'(reg_waddr), 32'd0);
        chk("rst_wdata", reg_wdata, 32'd0);
        chk("rst_stall", 32'(exu_stall), 32'd0);
        chk("rst_err", 32'(err_ovf), 32'd0);

        for (int r = 0; r < 24; r++) begin
            tb_wen = vecs[r].wen;
            tb_clr = vecs[r].clr;
            for (int i = 0; i < NR; i++) begin
                tb_addr[i] = vecs[r].addr[i*AW +: AW];
                tb_data[i] = vecs[r].data[i*DW +: DW];
            end
            tick(1'b0);
            chk($sformatf("v%0d.wen", r), 32'(reg_wen), 32'(vecs[r].ew));
            chk($sformatf("v%0d.waddr", r), 32'(reg_waddr), 32'(vecs[r].ea));
            chk($sformatf("v%0d.wdata", r), reg_wdata, vecs[r].ed);
            chk($sformatf("v%0d.stall", r), 32'(exu_stall), 32'(vecs[r].es));
            chk($sformatf("v%0d.err", r), 32'(err_ovf), 32'(vecs[r].ee));
        end

        // fairness: req0 (addr 1..15) and req1 (addr 16..31) every cycle, ptr starts at 1
        for (int k = 0; k < 12; k++) begin
            set_idle();
            tb_wen     = 4'b0011;
            tb_addr[0] = 5'($urandom_range(1, 15));
            tb_addr[1] = 5'($urandom_range(16, 31));
            tb_data[0] = $urandom;
            tb_data[1] = $urandom;
            tick(1'b1);
            exp_hi = (k % 2 == 0);
            chk("fair_wen", 32'(reg_wen), 32'd1);
            chk("fair_alt", 32'(reg_waddr >= 5'd16), 32'(exp_hi));
        end
        set_idle();
        tb_clr = 1'b1;
        tick(1'b1);

        // random traffic
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NR; i++) begin
                tb_wen[i]  = ($urandom_range(0, 9) < 4);
                tb_addr[i] = 5'($urandom_range(0, 7));
                tb_data[i] = $urandom;
            end
            tb_clr = ($urandom_range(0, 15) == 0);
            tick(1'b1);
        end

        // drain, then reset with three writes pending
        set_idle();
        repeat (5) tick(1'b1);
        tb_wen = 4'b1111;
        for (int i = 0; i < NR; i++) begin
            tb_addr[i] = 5'(i + 1);
            tb_data[i] = 32'hD00 + 32'(i);
        end
        tick(1'b1);
        chk("pre_rst_stall", 32'(exu_stall), 32'd1);
        set_idle();
        #2;
        hrstn = 1'b0;
        #1;
        chk("arst_wen", 32'(reg_wen), 32'd0);
        chk("arst_stall", 32'(exu_stall), 32'd0);
        chk("arst_waddr", 32'(reg_waddr), 32'd0);
        chk("arst_err", 32'(err_ovf), 32'd0);
        model_reset();
        @(posedge hclk);
        #1;
        hrstn = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick(1'b1);
            chk("post_rst_wen", 32'(reg_wen), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
